// File: rtl/day_code_setter.sv
// Day-of-week code source (0=mon..6=sun): midnight advance plus a debounced mode/up/down set mode.
// Optional macro SET_TIMEOUT_EN: leave set mode by itself after TIMEOUT_CYCLES cycles without a press.

module day_code_btn #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, prev_q, press_q;

    // Level follows the synchronized input only after an unbroken run of mismatches.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
            else                                   cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end

    assign press_o = press_q;
endmodule

module day_code_setter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_DIV       = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       day_tick,
    output logic [2:0] day,
    output logic       set_mode,
    output logic       blank
);
    localparam int NUM_BTN = 3;
    localparam int BW      = $clog2(BLINK_DIV);

    typedef enum logic {RUN = 1'b0, SET = 1'b1} state_e;

    logic [NUM_BTN-1:0] btn_raw, press;
    state_e             state_q, state_d;
    logic [2:0]         day_q, day_d;
    logic [BW-1:0]      blink_q, blink_d;
    logic               blank_q, blank_d, pend_q, pend_d;
    logic               mode_p, up_p, dn_p, timeout;

    assign btn_raw = {btn_down, btn_up, btn_mode};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        day_code_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (btn_raw[g]),
            .press_o(press[g])
        );
    end

    assign mode_p = press[0];
    assign up_p   = press[1];
    assign dn_p   = press[2];

    function automatic logic [2:0] day_inc(input logic [2:0] d);
        return (d == 3'd6) ? 3'd0 : d + 3'd1;
    endfunction

    function automatic logic [2:0] day_dec(input logic [2:0] d);
        return (d == 3'd0) ? 3'd6 : d - 3'd1;
    endfunction

`ifdef SET_TIMEOUT_EN
    localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [IW-1:0] idle_q, idle_d;

    assign timeout = (idle_q == IW'(TIMEOUT_CYCLES - 1)) && !(up_p || dn_p);

    always_comb begin
        idle_d = '0;
        if (state_q == SET && state_d == SET && !(up_p || dn_p)) idle_d = idle_q + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`else
    // Constant 0; the AND only keeps TIMEOUT_CYCLES referenced in this build.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mode_p) state_d = SET;
            SET:     if (mode_p || timeout) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Ticks seen while setting collapse into one advance applied on the way out.
    always_comb begin
        day_d   = day_q;
        blank_d = 1'b0;
        blink_d = '0;
        pend_d  = 1'b0;
        if (state_q == RUN) begin
            if (day_tick) day_d = day_inc(day_q);
        end else if (state_d == RUN) begin
            if (pend_q || day_tick) day_d = day_inc(day_q);
        end else begin
            pend_d  = pend_q | day_tick;
            blank_d = blank_q;
            if (up_p && !dn_p)      day_d = day_inc(day_q);
            else if (dn_p && !up_p) day_d = day_dec(day_q);
            if (blink_q == BW'(BLINK_DIV - 1)) blank_d = ~blank_q;
            else                               blink_d = blink_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            day_q   <= 3'd0;
            blink_q <= '0;
            blank_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            day_q   <= day_d;
            blink_q <= blink_d;
            blank_q <= blank_d;
            pend_q  <= pend_d;
        end
    end

    assign day      = day_q;
    assign set_mode = (state_q == SET);
    assign blank    = blank_q;
endmodule

// File: tb/tb_day_code_setter.sv
// Bench for day_code_setter: directed scenarios plus random button/tick traffic against a cycle model.
// Build with SET_TIMEOUT_EN defined to exercise the automatic set-mode exit.

module tb_day_code_setter;
    localparam int D   = 4;
    localparam int BD  = 8;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, day_tick = 1'b0;
    logic [2:0] day;
    logic       set_mode, blank;

    int n_chk = 0, n_fail = 0;

    // Reference model state: day as 0..6, set flag, age in set mode, last activity edge.
    int         cyc = 0, m_day = 0, m_age = 0, m_last = 0;
    bit         m_set = 0, m_pend = 0;
    logic [15:0] hist [3];
    bit         lvl [3];
    bit [2:0]   fpipe [3];

    int  rise_cyc = -1000, fall_cyc = -1000;
    bit  prev_set = 0;

    always #5 clk = ~clk;

    day_code_setter #(.DEBOUNCE_CYCLES(D), .BLINK_DIV(BD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .day_tick(day_tick),
        .day     (day),
        .set_mode(set_mode),
        .blank   (blank)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // A button counts as pressed once its raw level has been high for D straight samples;
    // the sample window lags by the 2-flop sync and the press acts two edges after acceptance.
    task automatic model_step();
        logic [2:0] raw;
        bit fire [3];
        bit all_new, fm, fu, fd, to, ex;
        cyc++;
        if (reset) begin
            m_day = 0; m_set = 0; m_pend = 0; m_age = 0; m_last = 0;
            for (int b = 0; b < 3; b++) begin
                hist[b] = '0; lvl[b] = 0; fpipe[b] = '0;
            end
            return;
        end
        raw = {btn_down, btn_up, btn_mode};
        for (int b = 0; b < 3; b++) begin
            fire[b]  = fpipe[b][0];
            fpipe[b] = fpipe[b] >> 1;
            hist[b]  = {hist[b][14:0], raw[b]};
            all_new  = 1;
            for (int i = 2; i <= D + 1; i++)
                if (hist[b][i] == lvl[b]) all_new = 0;
            if (all_new) begin
                lvl[b] = ~lvl[b];
                if (lvl[b]) fpipe[b][1] = 1'b1;
            end
        end
        fm = fire[0]; fu = fire[1]; fd = fire[2];
        if (!m_set) begin
            if (day_tick) m_day = (m_day + 1) % 7;
            if (fm) begin m_set = 1; m_age = 0; m_last = cyc; end
        end else begin
`ifdef SET_TIMEOUT_EN
            to = !fu && !fd && (cyc - m_last == TMO);
`else
            to = 0;
`endif
            ex = fm || to;
            m_age++;
            if (ex) begin
                if (m_pend || day_tick) m_day = (m_day + 1) % 7;
                m_pend = 0;
                m_set  = 0;
            end else begin
                if (day_tick) m_pend = 1;
                if (fu && !fd) m_day = (m_day + 1) % 7;
                if (fd && !fu) m_day = (m_day + 6) % 7;
                if (fu || fd)  m_last = cyc;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("day", int'(day), m_day);
        chk("set_mode", int'(set_mode), int'(m_set));
        chk("blank", int'(blank), m_set ? (m_age / BD) % 2 : 0);
        if (set_mode && !prev_set) rise_cyc = cyc;
        if (!set_mode && prev_set) fall_cyc = cyc;
        prev_set = set_mode;
    endtask

    task automatic press(input logic [2:0] which, input int hold);
        {btn_down, btn_up, btn_mode} = which;
        repeat (hold) cycle();
        {btn_down, btn_up, btn_mode} = 3'b000;
        repeat (D + 4) cycle();
    endtask

    task automatic tick();
        day_tick = 1'b1;
        cycle();
        day_tick = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, t, first, dur;
        bit rst_seg;

        repeat (2) cycle();
        reset = 1'b0;
        chk("rst_day", int'(day), 0);
        chk("rst_set", int'(set_mode), 0);
        chk("rst_blank", int'(blank), 0);

        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("tick_seq", int'(day), i % 7);
            chk("tick_run", int'(set_mode), 0);
        end

        start = cyc + 1;
        btn_mode = 1'b1;
        repeat (10) cycle();
        btn_mode = 1'b0;
        chk("mode_latency", rise_cyc - start, D + 3);
        t = 0;
        while (!blank && t < 40) begin cycle(); t++; end
        chk("blink_first", cyc - rise_cyc, BD);
        first = cyc;
        t = 0;
        while (blank && t < 40) begin cycle(); t++; end
        chk("blink_period", cyc - first, BD);

        btn_mode = 1'b1;
        repeat (3) cycle();
        btn_mode = 1'b0;
        repeat (10) cycle();
        chk("glitch_ignored", int'(set_mode), 1);

        press(3'b100, 5); chk("down_wrap", int'(day), 6);
        press(3'b010, 5); chk("up_wrap", int'(day), 0);
        press(3'b010, 5); chk("up_step", int'(day), 1);
        press(3'b110, 5); chk("up_down_same", int'(day), 1);
        press(3'b010, 5);
        press(3'b010, 5); chk("set_to_3", int'(day), 3);
        tick(); tick();
        chk("tick_held_in_set", int'(day), 3);
        press(3'b001, 5);
        chk("exit_pending_day", int'(day), 4);
        chk("exit_set_mode", int'(set_mode), 0);
        chk("exit_blank", int'(blank), 0);

        press(3'b001, 5);
        press(3'b010, 5);
        chk("set_to_5", int'(day), 5);
        t = 0;
        while (!blank && t < 40) begin cycle(); t++; end
        chk("blank_high", int'(blank), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midset_rst_day", int'(day), 0);
        chk("midset_rst_set", int'(set_mode), 0);
        chk("midset_rst_blank", int'(blank), 0);
        tick();
        chk("post_rst_tick", int'(day), 1);

`ifdef SET_TIMEOUT_EN
        press(3'b001, 5);
        t = 0;
        while (set_mode && t < 200) begin cycle(); t++; end
        chk("timeout_exit", fall_cyc - rise_cyc, TMO);
        press(3'b001, 5);
        t = 0;
        while (cyc < rise_cyc + 52 && t < 200) begin cycle(); t++; end
        press(3'b010, 5);
        t = 0;
        while (set_mode && t < 200) begin cycle(); t++; end
        chk("timeout_restart", fall_cyc - rise_cyc, 60 + TMO);
`else
        press(3'b001, 5);
        repeat (1000) cycle();
        chk("set_persists", int'(set_mode), 1);
        press(3'b001, 5);
`endif

        for (int s = 0; s < 200; s++) begin
            dur     = $urandom_range(1, 10);
            rst_seg = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 0) {btn_down, btn_up, btn_mode} = 3'b000;
            else {btn_down, btn_up, btn_mode} = 3'($urandom_range(0, 7));
            reset = rst_seg;
            for (int d = 0; d < dur; d++) begin
                day_tick = ($urandom_range(0, 7) == 0);
                cycle();
                reset = 1'b0;
            end
        end
        day_tick = 1'b0;
        {btn_down, btn_up, btn_mode} = 3'b000;
        repeat (D + 4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
